// File: rtl/frequency_meter.sv
// frequency_meter: counts rising edges of an asynchronous sig_in over back-to-back gate windows
//   clk_100mhz  in   sole clock
//   rst         in   synchronous reset, active-high
//   sig_in      in   asynchronous signal under measurement
//   enable      in   1 = run continuous windows, 0 = idle
//   freq_count  out  rising edges counted in the last completed window
//   freq_valid  out  one-cycle pulse when freq_count/overflow update
//   overflow    out  last completed window saturated the edge counter
module frequency_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   freq_valid,
    output logic                   overflow
);
    localparam int GW = $clog2(GATE_CYCLES);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t                 state;
    logic [GW-1:0]          gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] next_cnt;
    logic                   sat;
    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic                   edge_det;
    logic                   at_max;
    logic                   hit_max;
    logic                   gate_end;
    assign edge_det = sync2 & ~prev;
    assign at_max   = &edge_cnt;
    // an edge arriving while the counter is full is lost but remembered as saturation
    assign hit_max  = edge_det & at_max;
    assign next_cnt = edge_cnt + COUNT_WIDTH'(edge_det & ~at_max);
    assign gate_end = gate_cnt == GW'(GATE_CYCLES - 1);
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1      <= sig_in;
            sync2      <= sync1;
            prev       <= sync2;
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= MEASURE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gate_end) begin
                        // the edge seen in the closing cycle still belongs to this window
                        freq_count <= next_cnt;
                        overflow   <= sat | hit_max;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= next_cnt;
                        sat      <= sat | hit_max;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: scoreboard bench for frequency_meter, 32-bit and 8-bit counters side by side
module tb_frequency_meter;
    localparam int GATE = 1000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] count_a;
    logic        valid_a;
    logic        ovf_a;
    logic [7:0]  count_b;
    logic        valid_b;
    logic        ovf_b;
    frequency_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(32)) dut_a (
        .clk_100mhz(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .freq_count(count_a), .freq_valid(valid_a), .overflow(ovf_a)
    );
    frequency_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(8)) dut_b (
        .clk_100mhz(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .freq_count(count_b), .freq_valid(valid_b), .overflow(ovf_b)
    );
    always #5 clk = ~clk;
    typedef struct {
        int at;
        bit dc;
        int a;
        bit oa;
        int b;
        bit ob;
    } want_t;
    typedef struct {
        int period;
        bit level;
        int nwin;
        bit fdc;
        int fa;
        int a;
        bit oa;
        int b;
        bit ob;
    } step_t;
    want_t q[$];
    step_t steps[5];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_v = 0;
    int    period = 10;
    int    ph = 0;
    bit    level = 1'b0;
    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask
    task automatic push(input int at, input bit dc, input int a, input bit oa, input int b, input bit ob);
        want_t w;
        w.at = at;
        w.dc = dc;
        w.a  = a;
        w.oa = oa;
        w.b  = b;
        w.ob = ob;
        q.push_back(w);
    endtask
    task automatic tick();
        want_t w;
        @(posedge clk);
        #1;
        cyc++;
        if (period == 0) begin
            sig_in = level;
        end else begin
            if (ph >= period) ph = 0;
            sig_in = (ph < period / 2);
            ph++;
        end
        @(negedge clk);
        if (valid_a === 1'b1 || valid_b === 1'b1) begin
            last_v = cyc;
            if (q.size() == 0) begin
                chk("unexpected_valid", valid_a | valid_b, 0);
            end else begin
                w = q.pop_front();
                chk("valid_at", cyc, w.at);
                chk("valid_a", valid_a, 1);
                chk("valid_b", valid_b, 1);
                if (!w.dc) begin
                    chk("count_a", count_a, w.a);
                    chk("ovf_a", ovf_a, w.oa);
                    chk("count_b", count_b, w.b);
                    chk("ovf_b", ovf_b, w.ob);
                end
            end
        end
    endtask
    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            chk("valid_timeout", q.size(), 0);
            q.delete();
        end
    endtask
    initial begin
        int base;
        int en;
        int r;
        steps[0] = '{0,  1'b1, 2, 1'b1, 0, 0,   1'b0, 0,   1'b0};
        steps[1] = '{0,  1'b0, 1, 1'b0, 0, 0,   1'b0, 0,   1'b0};
        steps[2] = '{0,  1'b1, 2, 1'b0, 1, 0,   1'b0, 0,   1'b0};
        steps[3] = '{2,  1'b0, 3, 1'b1, 0, 500, 1'b0, 255, 1'b1};
        steps[4] = '{10, 1'b0, 2, 1'b1, 0, 100, 1'b0, 100, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_count_a", count_a, 0);
            chk("reset_ovf_a", ovf_a, 0);
            chk("reset_valid_a", valid_a, 0);
            chk("reset_count_b", count_b, 0);
        end
        rst = 1'b0;
        enable = 1'b0;
        repeat (50) tick();
        enable = 1'b1;
        en = cyc;
        for (int i = 0; i < 3; i++) push(en + GATE + 1 + GATE * i, 1'b0, 100, 1'b0, 100, 1'b0);
        drain(4 * GATE);
        foreach (steps[s]) begin
            period = steps[s].period;
            level  = steps[s].level;
            base   = last_v;
            for (int i = 0; i < steps[s].nwin; i++) begin
                if (i == 0) push(base + GATE, steps[s].fdc, steps[s].fa, 1'b0, steps[s].fa, 1'b0);
                else push(base + GATE * (i + 1), 1'b0, steps[s].a, steps[s].oa, steps[s].b, steps[s].ob);
            end
            drain(GATE * steps[s].nwin + 100);
        end
        base = last_v;
        while (cyc < base + 500) tick();
        enable = 1'b0;
        repeat (1500) tick();
        chk("hold_count_a", count_a, 100);
        chk("hold_ovf_a", ovf_a, 0);
        chk("hold_count_b", count_b, 100);
        enable = 1'b1;
        en = cyc;
        push(en + GATE + 1, 1'b0, 100, 1'b0, 100, 1'b0);
        push(en + 2 * GATE + 1, 1'b0, 100, 1'b0, 100, 1'b0);
        drain(2 * GATE + 200);
        base = last_v;
        while (cyc < base + 700) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_count_a", count_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_count_b", count_b, 0);
        r = cyc;
        push(r + GATE + 1, 1'b1, 0, 1'b0, 0, 1'b0);
        push(r + 2 * GATE + 1, 1'b0, 100, 1'b0, 100, 1'b0);
        drain(2 * GATE + 200);
        enable = 1'b0;
        repeat (10) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
